// File: rtl/led_fader.sv
// Soft-fade PWM driver: per-LED 4-bit levels ramp toward their targets once per fade step.
// Optional macro LED_FADER_GAMMA_EN maps levels through a perceptual gamma table.
module led_fader #(
  parameter int unsigned PRESCALE     = 15,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [15:0] i_signals,
  output logic [15:0] o_leds,
  output logic        o_period_start
);

  localparam int unsigned StpW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [15:0] PreMax = PRESCALE[15:0];
  localparam logic [StpW-1:0] StpMax = StpW'(STEP_PERIODS - 1);

`ifdef LED_FADER_GAMMA_EN
  localparam logic [3:0] GammaLut [16] = '{
    4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
    4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd10, 4'd12, 4'd15
  };
`endif

  logic [15:0]     r_pre;
  logic [3:0]      r_pwm;
  logic [StpW-1:0] r_stp;
  logic [3:0]      r_level [16];
  logic [15:0]     r_leds;
  logic            r_period_start;

  logic            w_tick;
  logic            w_period_end;
  logic            w_step;
  logic [3:0]      w_eff [16];
  logic [15:0]     w_leds_d;

  assign w_tick       = i_enable && (r_pre == PreMax);
  assign w_period_end = w_tick && (r_pwm == 4'd15);
  assign w_step       = w_period_end && (r_stp == StpMax);

  always_comb begin
    w_leds_d = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef LED_FADER_GAMMA_EN
      w_eff[i] = GammaLut[r_level[i]];
`else
      w_eff[i] = r_level[i];
`endif
      w_leds_d[i] = i_enable && ((w_eff[i] == 4'd15) || (r_pwm < w_eff[i]));
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pre <= '0;
      r_pwm <= '0;
      r_stp <= '0;
    end else if (i_enable) begin
      r_pre <= w_tick ? '0 : r_pre + 16'd1;
      if (w_tick) r_pwm <= r_pwm + 4'd1;
      if (w_period_end) r_stp <= w_step ? '0 : r_stp + StpW'(1);
    end
  end

  // Levels move only on the step edge, which coincides with the pwm wrap to slot 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 16; i++) r_level[i] <= '0;
    end else if (w_step) begin
      for (int i = 0; i < 16; i++) begin
        if (i_signals[i] && (r_level[i] != 4'd15)) begin
          r_level[i] <= r_level[i] + 4'd1;
        end else if (!i_signals[i] && (r_level[i] != 4'd0)) begin
          r_level[i] <= r_level[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_leds         <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_leds         <= w_leds_d;
      r_period_start <= w_period_end;
    end
  end

  assign o_leds         = r_leds;
  assign o_period_start = r_period_start;

endmodule
